// File: rtl/icache_pkg.sv
// Shared types and geometry constants for the direct-mapped instruction cache.
package icache_pkg;

    localparam int OFFSET_BITS   = 4;
    localparam int BLOCK_BITS    = 128;
    localparam int WORD_BITS     = 32;
    localparam int MEM_ADDR_BITS = 28;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MEM_READ = 2'd1,
        UPDATE   = 2'd2
    } state_t;

    function automatic logic [WORD_BITS-1:0] select_word(
        input logic [BLOCK_BITS-1:0] block,
        input logic [1:0]            sel
    );
        logic [WORD_BITS-1:0] word;
        case (sel)
            2'd0:    word = block[31:0];
            2'd1:    word = block[63:32];
            2'd2:    word = block[95:64];
            default: word = block[127:96];
        endcase
        return word;
    endfunction

endpackage

// File: rtl/icache_array.sv
// Valid/tag/data storage for the instruction cache: one combinational read
// port and one synchronous write port. Only the valid bits are reset.
module icache_array
    import icache_pkg::*;
#(
    parameter int INDEX_BITS = 3,
    parameter int TAG_BITS   = 32 - OFFSET_BITS - INDEX_BITS
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [INDEX_BITS-1:0] i_rd_index,
    output logic                  o_rd_valid,
    output logic [TAG_BITS-1:0]   o_rd_tag,
    output logic [BLOCK_BITS-1:0] o_rd_block,
    input  logic                  i_wr_en,
    input  logic [INDEX_BITS-1:0] i_wr_index,
    input  logic [TAG_BITS-1:0]   i_wr_tag,
    input  logic [BLOCK_BITS-1:0] i_wr_block
);

    localparam int SETS = 1 << INDEX_BITS;

    logic [SETS-1:0]       r_valid;
    logic [TAG_BITS-1:0]   r_tag  [SETS];
    logic [BLOCK_BITS-1:0] r_data [SETS];

    always_ff @(posedge clock) begin
        if (reset) begin
            r_valid <= '0;
        end else if (i_wr_en) begin
            r_valid[i_wr_index] <= 1'b1;
        end
    end

    // A write coinciding with reset is dropped so an abandoned fill leaves no trace.
    always_ff @(posedge clock) begin
        if (i_wr_en && !reset) begin
            r_tag[i_wr_index]  <= i_wr_tag;
            r_data[i_wr_index] <= i_wr_block;
        end
    end

    assign o_rd_valid = r_valid[i_rd_index];
    assign o_rd_tag   = r_tag[i_rd_index];
    assign o_rd_block = r_data[i_rd_index];

endmodule

// File: rtl/icache.sv
// Direct-mapped, read-only instruction cache with a three-state miss FSM.
// Optional hit/miss counters are enabled by defining ICACHE_STATS_EN.
module icache
    import icache_pkg::*;
#(
    parameter int INDEX_BITS = 3
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     read,
    input  logic [31:0]              address,
    output logic [WORD_BITS-1:0]     readdata,
    output logic                     busywait,
    output logic                     mem_read,
    output logic [MEM_ADDR_BITS-1:0] mem_address,
    input  logic [BLOCK_BITS-1:0]    mem_readdata,
    input  logic                     mem_busywait
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0]              hit_count,
    output logic [31:0]              miss_count
`endif
);

    localparam int TAG_BITS = 32 - OFFSET_BITS - INDEX_BITS;

    state_t                   r_state;
    state_t                   w_next_state;
    logic [MEM_ADDR_BITS-1:0] r_miss_addr;

    logic [INDEX_BITS-1:0]    w_index;
    logic [TAG_BITS-1:0]      w_tag;
    logic [1:0]               w_word;
    logic                     w_unused;
    logic                     w_rd_valid;
    logic [TAG_BITS-1:0]      w_rd_tag;
    logic [BLOCK_BITS-1:0]    w_rd_block;
    logic                     w_hit;
    logic                     w_fill;
    logic                     w_start_miss;

    assign w_index  = address[OFFSET_BITS +: INDEX_BITS];
    assign w_tag    = address[31 -: TAG_BITS];
    assign w_word   = address[3:2];
    assign w_unused = ^address[1:0];

    icache_array #(
        .INDEX_BITS (INDEX_BITS),
        .TAG_BITS   (TAG_BITS)
    ) u_array (
        .clock      (clock),
        .reset      (reset),
        .i_rd_index (w_index),
        .o_rd_valid (w_rd_valid),
        .o_rd_tag   (w_rd_tag),
        .o_rd_block (w_rd_block),
        .i_wr_en    (w_fill),
        .i_wr_index (r_miss_addr[INDEX_BITS-1:0]),
        .i_wr_tag   (r_miss_addr[MEM_ADDR_BITS-1 -: TAG_BITS]),
        .i_wr_block (mem_readdata)
    );

    assign w_hit        = read && w_rd_valid && (w_rd_tag == w_tag);
    assign w_start_miss = (r_state == IDLE) && read && !w_hit;
    assign readdata     = select_word(w_rd_block, w_word);
    assign mem_address  = r_miss_addr;

    // The miss register captures the block address only when a miss starts,
    // so later CPU address changes cannot redirect an in-flight fill.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= IDLE;
            r_miss_addr <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_start_miss) begin
                r_miss_addr <= address[31:OFFSET_BITS];
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        busywait     = 1'b0;
        mem_read     = 1'b0;
        w_fill       = 1'b0;
        case (r_state)
            IDLE: begin
                busywait = read && !w_hit;
                if (w_start_miss) begin
                    w_next_state = MEM_READ;
                end
            end
            MEM_READ: begin
                busywait = 1'b1;
                mem_read = 1'b1;
                if (!mem_busywait) begin
                    w_next_state = UPDATE;
                end
            end
            UPDATE: begin
                busywait     = 1'b1;
                w_fill       = 1'b1;
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

`ifdef ICACHE_STATS_EN
    logic [31:0] r_hit_count;
    logic [31:0] r_miss_count;

    // Both counters stick at all-ones instead of wrapping.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_hit_count  <= '0;
            r_miss_count <= '0;
        end else begin
            if ((r_state == IDLE) && w_hit && (r_hit_count != 32'hFFFF_FFFF)) begin
                r_hit_count <= r_hit_count + 32'd1;
            end
            if (w_start_miss && (r_miss_count != 32'hFFFF_FFFF)) begin
                r_miss_count <= r_miss_count + 32'd1;
            end
        end
    end

    assign hit_count  = r_hit_count;
    assign miss_count = r_miss_count;
`endif

endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: a latency-based cache model checked every
// cycle, plus directed fetch sequences with hand-computed expectations.
module tb_icache;

    localparam int MEM_LAT = 3;

    logic         clock = 1'b0;
    logic         reset;
    logic         read;
    logic [31:0]  address;
    logic [31:0]  readdata;
    logic         busywait;
    logic         mem_read;
    logic [27:0]  mem_address;
    logic [127:0] mem_readdata;
    logic         mem_busywait;
`ifdef ICACHE_STATS_EN
    logic [31:0]  hit_count;
    logic [31:0]  miss_count;
`endif

    int testsRun    = 0;
    int testsFailed = 0;
    bit checkEn     = 1'b0;

    icache dut (
        .clock        (clock),
        .reset        (reset),
        .read         (read),
        .address      (address),
        .readdata     (readdata),
        .busywait     (busywait),
        .mem_read     (mem_read),
        .mem_address  (mem_address),
        .mem_readdata (mem_readdata),
        .mem_busywait (mem_busywait)
`ifdef ICACHE_STATS_EN
        ,
        .hit_count    (hit_count),
        .miss_count   (miss_count)
`endif
    );

    always #5 clock = ~clock;

    // Instruction memory contents: block 0 holds the known program words.
    function automatic logic [31:0] wordOf(input logic [27:0] blk, input int w);
        logic [31:0] v;
        if (blk == 28'd0) begin
            case (w)
                0:       v = 32'h050000FA;
                1:       v = 32'h09010002;
                2:       v = 32'h11111111;
                default: v = 32'h22222222;
            endcase
        end else begin
            v = {blk[15:0], 16'(w)} ^ 32'h5A000000;
        end
        return v;
    endfunction

    function automatic logic [127:0] blockOf(input logic [27:0] blk);
        return {wordOf(blk, 3), wordOf(blk, 2), wordOf(blk, 1), wordOf(blk, 0)};
    endfunction

    // Memory stays busy for MEM_LAT cycles of each request, then presents data.
    int memCnt = 0;
    always @(posedge clock) memCnt <= mem_read ? memCnt + 1 : 0;
    assign mem_busywait = mem_read && (memCnt < MEM_LAT);
    assign mem_readdata = blockOf(mem_address);

    // Cache model: 8 sets, a fill takes MEM_LAT+2 cycles after the miss cycle,
    // mem_read is up for all but the last of them.
    bit          mValid [8];
    logic [24:0] mTag   [8];
    int          fillLeft = 0;
    logic [27:0] fillAddr = '0;
    int          mHits    = 0;
    int          mMisses  = 0;

    function automatic bit modelHit();
        int s;
        s = int'(address[6:4]);
        return read && (fillLeft == 0) && mValid[s] && (mTag[s] == address[31:7]);
    endfunction

    always @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) mValid[i] = 1'b0;
            fillLeft = 0;
            mHits    = 0;
            mMisses  = 0;
        end else if (fillLeft > 0) begin
            fillLeft = fillLeft - 1;
            if (fillLeft == 0) begin
                mValid[int'(fillAddr[2:0])] = 1'b1;
                mTag[int'(fillAddr[2:0])]   = fillAddr[27:3];
            end
        end else if (read) begin
            if (modelHit()) begin
                mHits = mHits + 1;
            end else begin
                fillLeft = MEM_LAT + 2;
                fillAddr = address[31:4];
                mMisses  = mMisses + 1;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        testsRun = testsRun + 1;
        if (act !== exp) begin
            testsFailed = testsFailed + 1;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    always @(negedge clock) begin
        if (checkEn) begin
            bit expBusy;
            bit expMemRead;
            expBusy    = (fillLeft > 0) || (read && !modelHit());
            expMemRead = (fillLeft > 1);
            checkOutput("busywait", 32'(busywait), 32'(expBusy));
            checkOutput("mem_read", 32'(mem_read), 32'(expMemRead));
            if (expMemRead) checkOutput("mem_address", 32'(mem_address), 32'(fillAddr));
            if (read && !expBusy) checkOutput("readdata", readdata, wordOf(address[31:4], int'(address[3:2])));
`ifdef ICACHE_STATS_EN
            checkOutput("hit_count", hit_count, 32'(mHits));
            checkOutput("miss_count", miss_count, 32'(mMisses));
`endif
        end
    end

    task automatic applyStimulus(input logic r, input logic [31:0] a, input logic rst);
        @(posedge clock);
        #1;
        read    = r;
        address = a;
        reset   = rst;
    endtask

    // Waits (bounded) for busywait to fall; reports stall cycles and the
    // first block address seen on the memory port.
    task automatic waitIdle(output int stall, output bit sawMemRead, output logic [27:0] seenAddr);
        stall      = 0;
        sawMemRead = 1'b0;
        seenAddr   = '0;
        forever begin
            @(negedge clock);
            if (mem_read === 1'b1 && !sawMemRead) begin
                sawMemRead = 1'b1;
                seenAddr   = mem_address;
            end
            if (busywait !== 1'b1) break;
            stall = stall + 1;
            if (stall > 100) begin
                checkOutput("busywait_timeout", 32'(stall), 32'd0);
                break;
            end
        end
    endtask

    initial begin
        int          stall;
        bit          sawMr;
        logic [27:0] seen;

        read    = 1'b0;
        address = '0;
        reset   = 1'b1;
        @(posedge clock);
        applyStimulus(1'b0, 32'h0, 1'b1);
        checkEn = 1'b1;
        applyStimulus(1'b0, 32'h0, 1'b0);
        @(negedge clock);
        checkOutput("reset_busywait", 32'(busywait), 32'd0);
        checkOutput("reset_mem_read", 32'(mem_read), 32'd0);
        checkOutput("reset_mem_address", 32'(mem_address), 32'd0);

        // Cold miss on block 0
        applyStimulus(1'b1, 32'h00000000, 1'b0);
        waitIdle(stall, sawMr, seen);
        checkOutput("cold_miss_stall", 32'(stall), 32'(MEM_LAT + 3));
        checkOutput("cold_miss_mem_read", 32'(sawMr), 32'd1);
        checkOutput("cold_miss_mem_address", 32'(seen), 32'h0000000);
        checkOutput("cold_miss_readdata", readdata, 32'h050000FA);

        // Same-block hit on word 1
        applyStimulus(1'b1, 32'h00000004, 1'b0);
        @(negedge clock);
        checkOutput("hit_busywait", 32'(busywait), 32'd0);
        checkOutput("hit_readdata", readdata, 32'h09010002);
        checkOutput("hit_mem_read", 32'(mem_read), 32'd0);

        // Conflict on index 0 with tag 1, then eviction of block 0
        applyStimulus(1'b1, 32'h00000080, 1'b0);
        waitIdle(stall, sawMr, seen);
        checkOutput("conflict_mem_address", 32'(seen), 32'h0000008);
        checkOutput("conflict_readdata", readdata, 32'h5A080000);
        applyStimulus(1'b1, 32'h00000000, 1'b0);
        waitIdle(stall, sawMr, seen);
        checkOutput("evict_stall", 32'(stall), 32'(MEM_LAT + 3));
        checkOutput("evict_readdata", readdata, 32'h050000FA);

        // Reset during the second MEM_READ cycle abandons the fill
        applyStimulus(1'b1, 32'h00000100, 1'b0);
        applyStimulus(1'b1, 32'h00000100, 1'b0);
        applyStimulus(1'b0, 32'h00000100, 1'b1);
        applyStimulus(1'b0, 32'h00000100, 1'b0);
        @(negedge clock);
        checkOutput("abort_mem_read", 32'(mem_read), 32'd0);
        checkOutput("abort_busywait", 32'(busywait), 32'd0);
        applyStimulus(1'b1, 32'h00000004, 1'b0);
        waitIdle(stall, sawMr, seen);
        checkOutput("after_reset_miss", 32'(sawMr), 32'd1);
        checkOutput("after_reset_readdata", readdata, 32'h09010002);

        // Dropping read and moving the address mid-miss must not disturb the fill
        applyStimulus(1'b1, 32'h00000024, 1'b0);
        applyStimulus(1'b0, 32'h0000003C, 1'b0);
        repeat (MEM_LAT + 3) applyStimulus(1'b0, 32'h0000003C, 1'b0);
        applyStimulus(1'b1, 32'h00000028, 1'b0);
        @(negedge clock);
        checkOutput("held_fill_hit", 32'(busywait), 32'd0);
        checkOutput("held_fill_readdata", readdata, 32'h5A020002);

        // No request: quiet outputs
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 32'h12345678 + 32'(i * 16), 1'b0);
            @(negedge clock);
            checkOutput("idle_busywait", 32'(busywait), 32'd0);
            checkOutput("idle_mem_read", 32'(mem_read), 32'd0);
        end

        applyStimulus(1'b0, 32'h0, 1'b0);
        @(negedge clock);
        checkEn = 1'b0;
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: got running, expected finished");
        $fatal(1, "[TB] timeout");
    end

endmodule

// File: doc/icache.md
ICACHE -- requirements
Module: icache

Interface
REQ-001 Parameter: INDEX_BITS, 3, log2 of number of direct-mapped sets (8 sets of 16-byte blocks).
REQ-002 Port: clock  input  1  single clock; all state updates on posedge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: read  input  1  CPU fetch request, level-held until busywait low.
REQ-005 Port: address  input  32  CPU byte address (PC); bits [1:0] ignored.
REQ-006 Port: readdata  output  32  fetched instruction word.
REQ-007 Port: busywait  output  1  CPU stall; high while request outstanding.
REQ-008 Port: mem_read  output  1  block read request to instruction memory.
REQ-009 Port: mem_address  output  28  block address to instruction memory (byte address [31:4]).
REQ-010 Port: mem_readdata  input  128  returned block, byte 0 in bits [7:0].
REQ-011 Port: mem_busywait  input  1  instruction memory busy.

Function
REQ-012 Address split SHALL be: offset [3:0], word select [3:2], index [3+INDEX_BITS:4], tag [31:4+INDEX_BITS] (25 bits at default).
REQ-013 Per set, storage SHALL be one valid bit, one tag, one 128-bit block.
REQ-014 Hit = read & valid[index] & (tag[index]==address tag); readdata SHALL be combinational word [32*word+31:32*word] of the indexed block.
REQ-015 busywait SHALL equal read & !hit in IDLE, 1 in MEM_READ and UPDATE, 0 otherwise.
REQ-016 FSM states SHALL be IDLE, MEM_READ, UPDATE.
REQ-017 IDLE -> MEM_READ at posedge when read & !hit; address[31:4] latched into a miss register.
REQ-018 In MEM_READ, mem_read=1 and mem_address=latched block address; both stable until exit.
REQ-019 MEM_READ -> UPDATE at first posedge where mem_busywait==0 is sampled after at least one cycle in MEM_READ.
REQ-020 UPDATE: mem_read=0; at posedge write mem_readdata, latched tag, valid=1 into latched index; -> IDLE.
REQ-021 Miss latency SHALL be memory latency + 2 cycles; hit latency 0 cycles (same cycle).
REQ-022 Changes to address or read during MEM_READ/UPDATE SHALL NOT affect the fill; re-evaluated in IDLE.
REQ-023 Deasserting read mid-miss SHALL NOT abort the fill.
REQ-024 Conflicting tag on same index SHALL overwrite the block (no write-back; read-only cache).
REQ-025 mem_read SHALL be 0 in IDLE.

Reset
REQ-026 reset SHALL clear all valid bits, set state IDLE, mem_read=0, mem_address=0, miss register=0.
REQ-027 Reset during MEM_READ or UPDATE SHALL abandon the fill without writing the array; next fetch misses.
REQ-028 Tag and data arrays SHALL NOT require reset.

Configuration
REQ-029 Macro ICACHE_STATS_EN SHALL, when defined, add outputs hit_count (32) and miss_count (32).
REQ-030 With ICACHE_STATS_EN: hit_count increments at posedge on IDLE & hit; miss_count on IDLE->MEM_READ; both cleared by reset; saturating at 0xFFFFFFFF.
REQ-031 Without ICACHE_STATS_EN: ports and counters absent; remaining behaviour identical.

Structure
REQ-032 Package icache_pkg SHALL hold state enum, OFFSET_BITS=4, BLOCK_BITS=128, WORD_BITS=32, MEM_ADDR_BITS=28.
REQ-033 Sub-module icache_array SHALL hold valid/tag/data storage with one combinational read port and one synchronous write port; FSM stays in icache.

Verification
REQ-034 Reset, read=1 address 0x00000000, memory word0=0x050000FA -> busywait=1, mem_read=1 mem_address=0x0000000; after fill readdata=0x050000FA, busywait=0.
REQ-035 Then address 0x00000004 (word1=0x09010002) -> same-cycle hit, readdata=0x09010002, mem_read stays 0.
REQ-036 Address 0x00000080 (index 0, tag 1) -> miss, mem_address=0x0000008; then 0x00000000 -> miss again (eviction).
REQ-037 Reset asserted second cycle of MEM_READ -> next posedge mem_read=0, busywait=0 with read=0; re-read 0x00000004 misses.
REQ-038 read=0, any address -> busywait=0, mem_read=0, no state change.
REQ-039 ICACHE_STATS_EN defined, sequence REQ-034..036 -> hit_count=1, miss_count=3.
